dmem_responder: RTL

//  Data-memory responder for the pipeline's MEM stage. Accepts one load/store

---
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage data-memory responder with programmable wait states
//               and pipeline stall. Optional misaligned-access error reporting
//               is enabled by defining DMEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWdata,
  output logic        ReqReady,
  output logic        Stall,
  output logic        RspValid,
  output logic [31:0] RspRdata
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        RspErr
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic                    access;

  // Request captured at accept; used for the access when it happens later.
  logic                    wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    err_q;

  // Operands of the access this cycle (live inputs when the access happens
  // on the accept edge itself, i.e. with zero wait states).
  logic                    acc_write;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    acc_err;
  logic                    req_err;

  logic [31:0]             mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err = |ReqAddr[1:0];
  logic unused_addr_bits;
  assign unused_addr_bits = ^ReqAddr[31:DEPTH_LOG2+2];
`else
  assign req_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ReqAddr[31:DEPTH_LOG2+2], ReqAddr[1:0]};
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge Clock) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ReqValid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            access     = 1'b1;
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          access     = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign ReqReady = (state == S_IDLE);
  assign Stall    = ((state == S_IDLE) & ReqValid) | (state == S_WAIT);

  // ---------------- wait-state counter and request latch ----------------
  always_ff @(posedge Clock) begin
    if (!Reset)                cnt <= '0;
    else if (accept)           cnt <= CNT_W'(WAIT_STATES);
    else if (state == S_WAIT)  cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge Clock) begin
    if (accept) begin
      wr_q    <= ReqWrite;
      idx_q   <= ReqAddr[DEPTH_LOG2+1:2];
      wdata_q <= ReqWdata;
      err_q   <= req_err;
    end
  end

  always_comb begin
    acc_write = wr_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_err   = err_q;
    if (state == S_IDLE) begin
      acc_write = ReqWrite;
      acc_idx   = ReqAddr[DEPTH_LOG2+1:2];
      acc_wdata = ReqWdata;
      acc_err   = req_err;
    end
  end

  // ---------------- storage and response ----------------
  // Gated by Reset so an aborted store never reaches the array.
  always_ff @(posedge Clock) begin
    if (Reset && access && acc_write && !acc_err)
      mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      RspValid <= 1'b0;
      RspRdata <= '0;
    end else begin
      RspValid <= access;
      if (access && !acc_write)
        RspRdata <= acc_err ? 32'd0 : mem[acc_idx];
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge Clock) begin
    if (!Reset) RspErr <= 1'b0;
    else        RspErr <= access & acc_err;
  end
`endif

endmodule

`default_nettype wire
